// File: rtl/aoi_truth_table_scanner_if.sv
// Purpose: bundles the scan request, gate stimulus/response and result signals
//          of the AOI truth-table scanner.
// Signals:
//   start    scan request (environment -> scanner)
//   y        AOI gate output (gate -> scanner)
//   a..d     gate inputs, {a,b,c,d} = vector index (scanner -> gate)
//   busy     scan in progress
//   done     one-cycle completion pulse
//   tt       captured truth table, bit i = y at vector i
//   err_cnt  vectors where y disagreed with the expected table
//   pass     last completed scan had no errors
interface aoi_truth_table_scanner_if;
  logic        start;
  logic        y;
  logic        a;
  logic        b;
  logic        c;
  logic        d;
  logic        busy;
  logic        done;
  logic [15:0] tt;
  logic [4:0]  err_cnt;
  logic        pass;

  // scanner side
  modport master (
    input  start, y,
    output a, b, c, d, busy, done, tt, err_cnt, pass
  );

  // environment / gate side
  modport slave (
    output start, y,
    input  a, b, c, d, busy, done, tt, err_cnt, pass
  );
endinterface

// File: rtl/aoi_truth_table_scanner.sv
// Purpose: on start, walks all 16 {a,b,c,d} vectors into an AOI gate, samples y
//          after SETTLE extra cycles per vector, builds the truth table and counts
//          disagreements with EXPECT.
// Ports:
//   clk    clock, rising edge
//   clr_n  asynchronous active-low reset
//   bus    aoi_truth_table_scanner_if.master (start, y in; a..d, busy, done,
//          tt, err_cnt, pass out, all registered)
module aoi_truth_table_scanner #(
  parameter int unsigned SETTLE = 2,
  parameter logic [15:0] EXPECT = 16'h0777
) (
  input logic                        clk,
  input logic                        clr_n,
  aoi_truth_table_scanner_if.master  bus
);

  localparam int unsigned IDX_W = 4;
  localparam int unsigned CNT_W = 4;
  localparam int unsigned ERR_W = 5;
  localparam int unsigned TT_W  = 16;

  typedef enum logic {IDLE, SCAN} state_t;

  state_t             state, state_nxt;
  logic [IDX_W-1:0]   idx, idx_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [IDX_W-1:0]   vec, vec_nxt;
  logic               busy, busy_nxt;
  logic               done, done_nxt;
  logic [TT_W-1:0]    tt, tt_nxt;
  logic [ERR_W-1:0]   err_cnt, err_cnt_nxt;
  logic               pass, pass_nxt;

  // Error total including the vector being sampled this cycle.
  logic [ERR_W-1:0]   err_sum;
  logic               last_vec;

  assign err_sum  = err_cnt + ERR_W'(bus.y ^ EXPECT[idx]);
  assign last_vec = (idx == IDX_W'(15));

  // State and datapath registers.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state   <= IDLE;
      idx     <= '0;
      cnt     <= '0;
      vec     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      tt      <= '0;
      err_cnt <= '0;
      pass    <= 1'b0;
    end else begin
      state   <= state_nxt;
      idx     <= idx_nxt;
      cnt     <= cnt_nxt;
      vec     <= vec_nxt;
      busy    <= busy_nxt;
      done    <= done_nxt;
      tt      <= tt_nxt;
      err_cnt <= err_cnt_nxt;
      pass    <= pass_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = SCAN;
      SCAN:    if (cnt == '0 && last_vec) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Next values of the registered outputs and counters.
  always_comb begin
    idx_nxt     = idx;
    cnt_nxt     = cnt;
    vec_nxt     = vec;
    busy_nxt    = busy;
    done_nxt    = 1'b0;
    tt_nxt      = tt;
    err_cnt_nxt = err_cnt;
    pass_nxt    = pass;
    case (state)
      IDLE: begin
        if (bus.start) begin
          busy_nxt    = 1'b1;
          idx_nxt     = '0;
          vec_nxt     = '0;
          cnt_nxt     = CNT_W'(SETTLE);
          tt_nxt      = '0;
          err_cnt_nxt = '0;
          pass_nxt    = 1'b0;
        end
      end
      SCAN: begin
        if (cnt != '0) begin
          cnt_nxt = cnt - CNT_W'(1);
        end else begin
          tt_nxt[idx] = bus.y;
          err_cnt_nxt = err_sum;
          if (!last_vec) begin
            idx_nxt = idx + IDX_W'(1);
            vec_nxt = idx + IDX_W'(1);
            cnt_nxt = CNT_W'(SETTLE);
          end else begin
            busy_nxt = 1'b0;
            done_nxt = 1'b1;
            vec_nxt  = '0;
            pass_nxt = (err_sum == '0);
          end
        end
      end
      default: ;
    endcase
  end

  assign bus.a       = vec[3];
  assign bus.b       = vec[2];
  assign bus.c       = vec[1];
  assign bus.d       = vec[0];
  assign bus.busy    = busy;
  assign bus.done    = done;
  assign bus.tt      = tt;
  assign bus.err_cnt = err_cnt;
  assign bus.pass    = pass;

endmodule

// File: tb/tb_aoi_truth_table_scanner.sv
module tb_aoi_truth_table_scanner;

  logic clk;
  logic clr_n;
  int   checks;
  int   errors;

  // 0 = golden AOI gate, 1 = y tied high, 2 = y tied low
  int   mode2;
  int   mode0;

  aoi_truth_table_scanner_if bus2 ();
  aoi_truth_table_scanner_if bus0 ();

  aoi_truth_table_scanner #(.SETTLE(2), .EXPECT(16'h0777)) u_dut2 (
    .clk   (clk),
    .clr_n (clr_n),
    .bus   (bus2)
  );

  aoi_truth_table_scanner #(.SETTLE(0), .EXPECT(16'h0777)) u_dut0 (
    .clk   (clk),
    .clr_n (clr_n),
    .bus   (bus0)
  );

  assign bus2.y = (mode2 == 0) ? ~((bus2.a & bus2.b) | (bus2.c & bus2.d)) : (mode2 == 1);
  assign bus0.y = (mode0 == 0) ? ~((bus0.a & bus0.b) | (bus0.c & bus0.d)) : (mode0 == 1);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] vec2();
    return {bus2.a, bus2.b, bus2.c, bus2.d};
  endfunction

  function automatic logic [3:0] vec0();
    return {bus0.a, bus0.b, bus0.c, bus0.d};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Edges from the start edge until done is seen, bounded by budget.
  task automatic wait_done(input bit sel0, input int budget, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!(sel0 ? bus0.done : bus2.done) && n < budget);
  endtask

  task automatic start2();
    bus2.start = 1'b1;
    tick();
    bus2.start = 1'b0;
  endtask

  task automatic check_results2(input string tag, input logic [15:0] tt,
                                input logic [4:0] err, input logic pass);
    check({tag, "_tt"}, 32'(bus2.tt), 32'(tt));
    check({tag, "_err"}, 32'(bus2.err_cnt), 32'(err));
    check({tag, "_pass"}, 32'(bus2.pass), 32'(pass));
    check({tag, "_vec"}, 32'(vec2()), 32'h0);
    check({tag, "_busy"}, 32'(bus2.busy), 32'h0);
  endtask

  initial begin
    int  n;
    bit  saw_idle;
    bit  saw_done;

    checks     = 0;
    errors     = 0;
    mode2      = 0;
    mode0      = 0;
    clr_n      = 1'b0;
    bus2.start = 1'b1;
    bus0.start = 1'b1;

    // 1: reset with start held high
    saw_done = 1'b0;
    saw_idle = 1'b1;
    repeat (3) begin
      tick();
      if (bus2.busy || bus0.busy) saw_idle = 1'b0;
      if (bus2.done || bus0.done) saw_done = 1'b1;
    end
    check("rst_busy_stays_low", 32'(saw_idle), 32'h1);
    check("rst_no_done", 32'(saw_done), 32'h0);
    check("rst_vec", 32'(vec2()), 32'h0);
    check("rst_tt", 32'(bus2.tt), 32'h0);
    check("rst_err", 32'(bus2.err_cnt), 32'h0);
    check("rst_pass", 32'(bus2.pass), 32'h0);
    check("rst_dut0_all", 32'({bus0.busy, bus0.done, bus0.pass, vec0(), bus0.err_cnt}), 32'h0);
    bus2.start = 1'b0;
    bus0.start = 1'b0;
    clr_n      = 1'b1;
    tick();

    // 2: golden gate, SETTLE=2
    mode2 = 0;
    start2();
    check("gold_busy_after_start", 32'(bus2.busy), 32'h1);
    wait_done(1'b0, 100, n);
    check("gold_done_latency", 32'(n), 32'd48);
    check_results2("gold", 16'h0777, 5'd0, 1'b1);
    tick();
    check("gold_done_one_cycle", 32'(bus2.done), 32'h0);
    check("gold_tt_holds", 32'(bus2.tt), 32'h0777);

    // 3: y stuck high, then stuck low
    mode2 = 1;
    start2();
    wait_done(1'b0, 100, n);
    check("y1_done_latency", 32'(n), 32'd48);
    check_results2("y1", 16'hFFFF, 5'd7, 1'b0);
    mode2 = 2;
    start2();
    wait_done(1'b0, 100, n);
    check("y0_done_latency", 32'(n), 32'd48);
    check_results2("y0", 16'h0000, 5'd9, 1'b0);

    // 4: start held high through a scan (y stuck low), then golden rescan
    tick();
    bus2.start = 1'b1;
    tick();
    check("hold_busy", 32'(bus2.busy), 32'h1);
    saw_idle = 1'b0;
    n = 0;
    do begin
      tick();
      n++;
      if (!bus2.busy && !bus2.done) saw_idle = 1'b1;
    end while (!bus2.done && n < 100);
    check("hold_done_latency", 32'(n), 32'd48);
    check("hold_no_restart", 32'(saw_idle), 32'h0);
    check("hold_err_before", 32'(bus2.err_cnt), 32'd9);
    mode2 = 0;
    tick();
    bus2.start = 1'b0;
    check("hold_restart_busy", 32'(bus2.busy), 32'h1);
    check("hold_restart_tt_clr", 32'(bus2.tt), 32'h0);
    check("hold_restart_err_clr", 32'(bus2.err_cnt), 32'h0);
    check("hold_restart_done_low", 32'(bus2.done), 32'h0);
    wait_done(1'b0, 100, n);
    check("hold_rescan_latency", 32'(n), 32'd48);
    check_results2("hold_rescan", 16'h0777, 5'd0, 1'b1);

    // 5: reset while vector 5 is driven
    start2();
    n = 0;
    while (vec2() != 4'd5 && n < 100) begin
      tick();
      n++;
    end
    check("abort_reached_vec5", 32'(vec2()), 32'h5);
    #2;
    clr_n = 1'b0;
    #1;
    check("abort_async_busy", 32'(bus2.busy), 32'h0);
    check("abort_async_vec", 32'(vec2()), 32'h0);
    check("abort_async_tt", 32'(bus2.tt), 32'h0);
    check("abort_async_err", 32'(bus2.err_cnt), 32'h0);
    saw_done = 1'b0;
    repeat (2) begin
      tick();
      if (bus2.done) saw_done = 1'b1;
    end
    check("abort_no_done", 32'(saw_done), 32'h0);
    clr_n = 1'b1;
    tick();
    start2();
    wait_done(1'b0, 100, n);
    check("abort_rescan_latency", 32'(n), 32'd48);
    check_results2("abort_rescan", 16'h0777, 5'd0, 1'b1);

    // 6: SETTLE=0 steps one vector per edge
    mode0 = 0;
    bus0.start = 1'b1;
    tick();
    bus0.start = 1'b0;
    check("s0_busy", 32'(bus0.busy), 32'h1);
    check("s0_vec_0", 32'(vec0()), 32'h0);
    for (int i = 1; i < 16; i++) begin
      tick();
      check($sformatf("s0_vec_%0d", i), 32'(vec0()), 32'(i));
    end
    tick();
    check("s0_done_at_16", 32'(bus0.done), 32'h1);
    check("s0_tt", 32'(bus0.tt), 32'h0777);
    check("s0_err", 32'(bus0.err_cnt), 32'h0);
    check("s0_pass", 32'(bus0.pass), 32'h1);
    check("s0_vec_back", 32'(vec0()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
